// File: rtl/decode_stage.sv
// Decode stage: instruction decode, register file, scoreboard-based dependency
// stall and the AGEX pipeline latch. One cycle from DE inputs to AGEX outputs.
// Optional feature macro: DECODE_BYPASS_EN (writeback-to-decode forwarding).
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] de_npc,
  input  logic [15:0] de_ir,
  input  logic        de_v,
  input  logic        mem_stall,
  input  logic        wb_v,
  input  logic        wb_ld_reg,
  input  logic [2:0]  wb_dr,
  input  logic [15:0] wb_data,
  input  logic        wb_ld_cc,
  output logic        dep_stall,
  output logic        v_de_br_stall,
  output logic        ld_de,
  output logic [15:0] agex_npc,
  output logic [15:0] agex_ir,
  output logic [15:0] agex_sr1,
  output logic [15:0] agex_sr2,
  output logic [2:0]  agex_dr,
  output logic        agex_ld_reg,
  output logic        agex_ld_cc,
  output logic        agex_v
);

  typedef enum logic [3:0] {
    OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB   = 4'h3,
    OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDW = 4'h6, OP_STW   = 4'h7,
    OP_RTI = 4'h8, OP_XOR = 4'h9, OP_ILA = 4'hA, OP_ILB   = 4'hB,
    OP_JMP = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP  = 4'hF
  } opcode_e;

  opcode_e     op;
  logic [2:0]  sr1_idx, sr2_idx, dest;
  logic        sr1_used, sr2_used, cc_used, ld_reg, ld_cc, br_ctl;
  logic        sr1_busy, sr2_busy, cc_busy, issue;
  logic [15:0] sr1_val, sr2_val;

  logic [15:0] rf      [8];
  logic [1:0]  reg_cnt [8];
  logic [1:0]  cc_cnt;

  assign op      = opcode_e'(de_ir[15:12]);
  assign sr1_idx = de_ir[8:6];

  // Saturating in-flight counter; simultaneous increment and decrement cancel.
  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic inc,
                                          input logic dec);
    if (inc && !dec && c != 2'd3) return c + 2'd1;
    if (dec && !inc && c != 2'd0) return c - 2'd1;
    return c;
  endfunction

  // Field decode: which sources are read, which destination/CC are written.
  always_comb begin
    // NOTE: every output gets a default first, so no opcode path can infer a latch.
    sr1_used = 1'b0;
    sr2_used = 1'b0;
    cc_used  = 1'b0;
    ld_reg   = 1'b0;
    ld_cc    = 1'b0;
    br_ctl   = 1'b0;
    dest     = 3'd0;
    sr2_idx  = de_ir[2:0];
    case (op)
      OP_ADD, OP_AND, OP_XOR: begin
        sr1_used = 1'b1;
        sr2_used = ~de_ir[5];
        ld_reg   = 1'b1;
        dest     = de_ir[11:9];
        ld_cc    = 1'b1;
      end
      OP_SHF, OP_LDB, OP_LDW: begin
        sr1_used = 1'b1;
        ld_reg   = 1'b1;
        dest     = de_ir[11:9];
        ld_cc    = 1'b1;
      end
      OP_STB, OP_STW: begin
        sr1_used = 1'b1;
        sr2_used = 1'b1;
        sr2_idx  = de_ir[11:9];
      end
      OP_LEA: begin
        ld_reg = 1'b1;
        dest   = de_ir[11:9];
      end
      OP_JMP: begin
        sr1_used = 1'b1;
        br_ctl   = 1'b1;
      end
      OP_JSR: begin
        sr1_used = ~de_ir[11];
        ld_reg   = 1'b1;
        dest     = 3'd7;
        br_ctl   = 1'b1;
      end
      OP_TRAP: begin
        ld_reg = 1'b1;
        dest   = 3'd7;
        br_ctl = 1'b1;
      end
      OP_BR: begin
        cc_used = (de_ir[11:9] != 3'd0);
        br_ctl  = 1'b1;
      end
      OP_RTI:  br_ctl = 1'b1;
      default: ; // illegal opcodes: no sources, no destination, no CC
    endcase
  end

  // Source availability and operand values, with optional writeback forwarding.
  always_comb begin
`ifdef DECODE_BYPASS_EN
    logic hit1, hit2, hitc;
    hit1     = wb_v & wb_ld_reg & (wb_dr == sr1_idx);
    hit2     = wb_v & wb_ld_reg & (wb_dr == sr2_idx);
    hitc     = wb_v & wb_ld_cc;
    sr1_busy = (reg_cnt[sr1_idx] != 2'd0) & ~((reg_cnt[sr1_idx] == 2'd1) & hit1);
    sr2_busy = (reg_cnt[sr2_idx] != 2'd0) & ~((reg_cnt[sr2_idx] == 2'd1) & hit2);
    cc_busy  = (cc_cnt != 2'd0) & ~((cc_cnt == 2'd1) & hitc);
    sr1_val  = hit1 ? wb_data : rf[sr1_idx];
    sr2_val  = hit2 ? wb_data : rf[sr2_idx];
`else
    sr1_busy = (reg_cnt[sr1_idx] != 2'd0);
    sr2_busy = (reg_cnt[sr2_idx] != 2'd0);
    cc_busy  = (cc_cnt != 2'd0);
    sr1_val  = rf[sr1_idx];
    sr2_val  = rf[sr2_idx];
`endif
  end

  assign dep_stall     = de_v & ((sr1_used & sr1_busy) | (sr2_used & sr2_busy) |
                                 (cc_used & cc_busy));
  assign v_de_br_stall = de_v & br_ctl;
  assign ld_de         = ~dep_stall & ~mem_stall;
  assign issue         = de_v & ~dep_stall & ~mem_stall;

  // Register file and scoreboard counters; reset wins over writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is cleared on reset because software may read it before writing.
      for (int i = 0; i < 8; i++) begin
        rf[i]      <= 16'd0;
        reg_cnt[i] <= 2'd0;
      end
      cc_cnt <= 2'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wb_v && wb_ld_reg && wb_dr == 3'(i)) rf[i] <= wb_data;
        reg_cnt[i] <= cnt_next(reg_cnt[i], issue & ld_reg & (dest == 3'(i)),
                               wb_v & wb_ld_reg & (wb_dr == 3'(i)));
      end
      cc_cnt <= cnt_next(cc_cnt, issue & ld_cc, wb_v & wb_ld_cc);
    end
  end

  // AGEX latch: frozen by mem_stall, loaded on issue, bubble otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      agex_npc    <= 16'd0;
      agex_ir     <= 16'd0;
      agex_sr1    <= 16'd0;
      agex_sr2    <= 16'd0;
      agex_dr     <= 3'd0;
      agex_ld_reg <= 1'b0;
      agex_ld_cc  <= 1'b0;
      agex_v      <= 1'b0;
    end else if (!mem_stall) begin
      if (issue) begin
        agex_npc    <= de_npc;
        agex_ir     <= de_ir;
        agex_sr1    <= sr1_val;
        agex_sr2    <= sr2_val;
        agex_dr     <= dest;
        agex_ld_reg <= ld_reg;
        agex_ld_cc  <= ld_cc;
        agex_v      <= 1'b1;
      end else begin
        agex_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// traffic, checked by a scoreboard against a behavioural model of the stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] de_npc, de_ir;
  logic        de_v, mem_stall, wb_v, wb_ld_reg, wb_ld_cc;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;
  logic        dep_stall, v_de_br_stall, ld_de;
  logic [15:0] agex_npc, agex_ir, agex_sr1, agex_sr2;
  logic [2:0]  agex_dr;
  logic        agex_ld_reg, agex_ld_cc, agex_v;

  decode_stage dut (
    .clk(clk), .reset(reset), .de_npc(de_npc), .de_ir(de_ir), .de_v(de_v),
    .mem_stall(mem_stall), .wb_v(wb_v), .wb_ld_reg(wb_ld_reg), .wb_dr(wb_dr),
    .wb_data(wb_data), .wb_ld_cc(wb_ld_cc), .dep_stall(dep_stall),
    .v_de_br_stall(v_de_br_stall), .ld_de(ld_de), .agex_npc(agex_npc),
    .agex_ir(agex_ir), .agex_sr1(agex_sr1), .agex_sr2(agex_sr2),
    .agex_dr(agex_dr), .agex_ld_reg(agex_ld_reg), .agex_ld_cc(agex_ld_cc),
    .agex_v(agex_v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] npc, ir, sr1, sr2;
    logic [2:0]  dr;
    logic        ld_reg, ld_cc, chk1, chk2;
  } agex_t;

  typedef struct {
    logic       s1, s2, cc, ldr, ldc, br;
    logic [2:0] i1, i2, dr;
  } dec_t;

  agex_t       exp_q[$];
  agex_t       last_exp;
  logic        last_v;
  int          checks   = 0;
  int          failures = 0;

  // Reference state: architectural registers and pending-write counts.
  logic [15:0] m_rf  [8];
  int          m_cnt [8];
  int          m_cc;
  logic        issued, seen_dep, seen_br, seen_ld_de;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction rules from the opcode table.
  function automatic dec_t decode(input logic [15:0] ir);
    dec_t d;
    int   op;
    op    = int'(ir[15:12]);
    d     = '{default: '0};
    d.i1  = ir[8:6];
    d.i2  = ir[2:0];
    d.s1  = (op inside {1, 5, 9, 13, 2, 6, 3, 7, 12}) || (op == 4 && !ir[11]);
    if (op inside {1, 5, 9}) d.s2 = !ir[5];
    if (op inside {3, 7}) begin d.s2 = 1'b1; d.i2 = ir[11:9]; end
    if (op inside {1, 5, 9, 13, 2, 6, 14}) begin d.ldr = 1'b1; d.dr = ir[11:9]; end
    if (op inside {4, 15}) begin d.ldr = 1'b1; d.dr = 3'd7; end
    d.ldc = op inside {1, 5, 9, 13, 2, 6};
    d.cc  = (op == 0) && (ir[11:9] != 3'd0);
    d.br  = op inside {0, 4, 12, 15, 8};
    return d;
  endfunction

  function automatic bit wb_hit(input logic [2:0] r);
    return wb_v && wb_ld_reg && wb_dr == r;
  endfunction

  function automatic bit src_busy(input logic [2:0] r);
`ifdef DECODE_BYPASS_EN
    return m_cnt[r] != 0 && !(m_cnt[r] == 1 && wb_hit(r));
`else
    return m_cnt[r] != 0;
`endif
  endfunction

  function automatic bit cc_busy();
`ifdef DECODE_BYPASS_EN
    return m_cc != 0 && !(m_cc == 1 && wb_v && wb_ld_cc);
`else
    return m_cc != 0;
`endif
  endfunction

  function automatic logic [15:0] src_val(input logic [2:0] r);
`ifdef DECODE_BYPASS_EN
    if (wb_hit(r)) return wb_data;
`endif
    return m_rf[r];
  endfunction

  function automatic int sat(input int v);
    return (v > 3) ? 3 : (v < 0) ? 0 : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin m_rf[i] = 16'd0; m_cnt[i] = 0; end
    m_cc = 0;
  endtask

  // Check decode-cycle outputs, predict the issue, advance the model one clock.
  task automatic step();
    dec_t  d;
    logic  dep;
    agex_t e;
    #1;
    d   = decode(de_ir);
    dep = de_v && ((d.s1 && src_busy(d.i1)) || (d.s2 && src_busy(d.i2)) ||
                   (d.cc && cc_busy()));
    seen_dep   = dep_stall;
    seen_br    = v_de_br_stall;
    seen_ld_de = ld_de;
    check("dep_stall", dep_stall, dep);
    check("v_de_br_stall", v_de_br_stall, de_v && d.br);
    check("ld_de", ld_de, !dep && !mem_stall);
    issued = de_v && !dep && !mem_stall && !reset;
    if (issued) begin
      e = '{npc: de_npc, ir: de_ir, sr1: src_val(d.i1), sr2: src_val(d.i2),
            dr: d.dr, ld_reg: d.ldr, ld_cc: d.ldc, chk1: d.s1, chk2: d.s2};
      exp_q.push_back(e);
    end
    if (reset) model_clear();
    else begin
      for (int r = 0; r < 8; r++)
        m_cnt[r] = sat(m_cnt[r] + ((issued && d.ldr && d.dr == 3'(r)) ? 1 : 0)
                                - (wb_hit(3'(r)) ? 1 : 0));
      m_cc = sat(m_cc + ((issued && d.ldc) ? 1 : 0) - ((wb_v && wb_ld_cc) ? 1 : 0));
      if (wb_v && wb_ld_reg) m_rf[wb_dr] = wb_data;
    end
    @(negedge clk);
  endtask

  task automatic set_wb(input logic v, input logic lr, input logic [2:0] dr,
                        input logic [15:0] data, input logic lc);
    wb_v = v; wb_ld_reg = lr; wb_dr = dr; wb_data = data; wb_ld_cc = lc;
  endtask

  task automatic set_de(input logic v, input logic [15:0] ir, input logic [15:0] npc);
    de_v = v; de_ir = ir; de_npc = npc;
  endtask

  // Monitor: compares the AGEX latch every cycle against the scoreboard.
  always @(posedge clk) begin
    agex_t e;
    #1;
    if (reset) begin
      check("rst_agex_v", agex_v, 1'b0);
      check("rst_agex_npc", agex_npc, 16'd0);
      check("rst_agex_ir", agex_ir, 16'd0);
      check("rst_agex_sr1", agex_sr1, 16'd0);
      check("rst_agex_sr2", agex_sr2, 16'd0);
      check("rst_agex_ctl", {agex_dr, agex_ld_reg, agex_ld_cc}, 16'd0);
      last_v = 1'b0;
    end else if (mem_stall) begin
      check("hold_agex_v", agex_v, last_v);
      if (last_v) begin
        check("hold_agex_ir", agex_ir, last_exp.ir);
        check("hold_agex_npc", agex_npc, last_exp.npc);
        check("hold_agex_dr", agex_dr, last_exp.dr);
      end
    end else if (agex_v) begin
      if (exp_q.size() == 0) check("spurious_agex_v", agex_v, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("agex_npc", agex_npc, e.npc);
        check("agex_ir", agex_ir, e.ir);
        if (e.chk1) check("agex_sr1", agex_sr1, e.sr1);
        if (e.chk2) check("agex_sr2", agex_sr2, e.sr2);
        check("agex_dr", agex_dr, e.dr);
        check("agex_ld_reg", agex_ld_reg, e.ld_reg);
        check("agex_ld_cc", agex_ld_cc, e.ld_cc);
        last_exp = e;
      end
      last_v = 1'b1;
    end else begin
      check("missed_issue", 16'(exp_q.size()), 16'd0);
      last_v = 1'b0;
    end
  end

  initial begin
    int n;
    last_v   = 1'b0;
    last_exp = '{default: '0};
    reset = 1'b1; mem_stall = 1'b0;
    set_de(1'b0, 16'h0000, 16'h0000);
    set_wb(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    model_clear();
    @(negedge clk);
    step();
    reset = 1'b0;

    // Preload R2=5, R3=7 then ADD R1,R2,R3.
    set_wb(1'b1, 1'b1, 3'd2, 16'h0005, 1'b0); step();
    set_wb(1'b1, 1'b1, 3'd3, 16'h0007, 1'b0); step();
    set_wb(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    set_de(1'b1, 16'h1283, 16'h3002); step();
    check("add_issue", issued, 1'b1);

    // ADD R2,R1,R1 stalls on R1 until its writeback.
    set_de(1'b1, 16'h1441, 16'h3004);
    for (int i = 0; i < 2; i++) begin
      step();
      check("raw_dep_stall", seen_dep, 1'b1);
      check("raw_ld_de", seen_ld_de, 1'b0);
    end
    set_wb(1'b1, 1'b1, 3'd1, 16'h00AA, 1'b0); step();
    set_wb(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    n = 0;
    while (!issued && n < 4) begin step(); n++; end
`ifdef DECODE_BYPASS_EN
    check("wb_release_extra_cycles", 16'(n), 16'd0);
`else
    check("wb_release_extra_cycles", 16'(n), 16'd1);
`endif

    // BRz with CC busy, then with CC clear.
    set_de(1'b1, 16'h0402, 16'h3006); step();
    check("br_cc_busy_dep", seen_dep, 1'b1);
    check("br_cc_busy_br", seen_br, 1'b1);
    set_de(1'b0, 16'h0402, 16'h3006);
    set_wb(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1);
    step(); step();
    set_wb(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    set_de(1'b1, 16'h0402, 16'h3006); step();
    check("br_cc_free_dep", seen_dep, 1'b0);
    check("br_cc_free_br", seen_br, 1'b1);

    // mem_stall freezes the latch for three cycles, then ADD R3,R1,#5 issues.
    set_de(1'b1, 16'h1665, 16'h3008);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mem_stall_ld_de", seen_ld_de, 1'b0);
    end
    mem_stall = 1'b0; step();
    check("mem_release_issue", issued, 1'b1);
    set_de(1'b1, 16'h18C3, 16'h300A); step();
    check("r3_pending_dep", seen_dep, 1'b1);

    // Reset with in-flight state and a valid AGEX latch.
    set_de(1'b1, 16'h1665, 16'h300C); step();
    reset = 1'b1; step();
    reset = 1'b0;
    set_de(1'b1, 16'h18C3, 16'h300E); step();
    check("post_reset_dep", seen_dep, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      mem_stall = ($urandom_range(0, 4) == 0);
      set_de($urandom_range(0, 9) < 8, 16'($urandom), 16'($urandom));
      set_wb($urandom_range(0, 9) < 4, 1'($urandom), 3'($urandom),
             16'($urandom), 1'($urandom));
      step();
    end
    reset = 1'b0; mem_stall = 1'b0;
    set_de(1'b0, 16'h0000, 16'h0000);
    set_wb(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    step();
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 de_npc, de_ir  in  16 each  DE latch contents from fetch: PC+2 and instruction.
REQ-004 de_v  in  1  DE latch valid.
REQ-005 mem_stall  in  1  downstream memory stall; freezes AGEX latch.
REQ-006 wb_v, wb_ld_reg  in  1 each  writeback valid, writeback writes register.
REQ-007 wb_dr  in  3  writeback destination; wb_data  in  16  writeback value.
REQ-008 wb_ld_cc  in  1  writeback updates condition codes.
REQ-009 dep_stall  out  1  register/CC dependency stall to fetch.
REQ-010 v_de_br_stall  out  1  valid control-flow instruction in decode.
REQ-011 ld_de  out  1  DE latch may load next fetch output.
REQ-012 agex_npc, agex_ir, agex_sr1, agex_sr2  out  16 each  AGEX latch: npc, ir, source values.
REQ-013 agex_dr  out  3, agex_ld_reg  out  1, agex_ld_cc  out  1, agex_v  out  1  AGEX control fields.

Function
REQ-014 Opcode de_ir[15:12]: BR 0000, ADD 0001, LDB 0010, STB 0011, JSR 0100, AND 0101, LDW 0110, STW 0111, RTI 1000, XOR 1001, JMP 1100, SHF 1101, LEA 1110, TRAP 1111; 1010/1011 illegal.
REQ-015 Internal 8x16 register file; reads combinational, write on clk when wb_v & wb_ld_reg.
REQ-016 SR1 = ir[8:6] used by ADD, AND, XOR, SHF, LDB, LDW, STB, STW, JMP, JSR with ir[11]=0.
REQ-017 SR2 = ir[2:0] used by ADD/AND/XOR with ir[5]=0; STB/STW use ir[11:9] as SR2 (store data).
REQ-018 Dest: ADD, AND, XOR, SHF, LDB, LDW, LEA -> ir[11:9]; JSR, TRAP -> 7; others none (agex_ld_reg=0).
REQ-019 agex_ld_cc = 1 for ADD, AND, XOR, SHF, LDB, LDW; BR with ir[11:9]!=0 consumes CC.
REQ-020 Scoreboard: per-register 2-bit in-flight counter plus one 2-bit CC counter.
REQ-021 Counter +1 when instruction issues to AGEX with ld flag; -1 on wb_v with matching ld flag/dr; both same cycle -> unchanged; saturate at 3 and 0.
REQ-022 Issue = de_v & ~dep_stall & ~mem_stall.
REQ-023 dep_stall = de_v & any used source (SR1, SR2, CC) has counter != 0, except as in REQ-031.
REQ-024 v_de_br_stall = de_v & opcode in {BR, JSR, JMP, TRAP, RTI}; independent of dep_stall.
REQ-025 ld_de = ~dep_stall & ~mem_stall.
REQ-026 AGEX latch: mem_stall=1 -> hold all fields; else on issue load decoded fields, agex_v=1; else (dep_stall or ~de_v) agex_v=0, other fields don't-care-held.
REQ-027 Latency: one cycle from DE inputs to AGEX outputs.
REQ-028 Illegal opcodes issue with agex_v=1, no sources, no dest, agex_ld_cc=0.
REQ-029 Register 0..7 addressing modulo 3 bits; no out-of-range case.

Reset
REQ-030 reset=1 at clk edge: register file all 0, all counters 0, agex_v=0, all agex_* fields 0; reset overrides mem_stall and writeback; dep_stall=0 while counters 0.

Configuration
REQ-031 DECODE_BYPASS_EN defined: source whose counter==1 and written by this cycle's writeback does not stall; wb_data forwarded to agex_sr1/agex_sr2; same for CC with wb_ld_cc.
REQ-032 DECODE_BYPASS_EN undefined: no forwarding; stall until counter==0, read from register file next cycle.

Verification
REQ-033 Reset, then de_v=1, de_ir=0x1283 (ADD R1,R2,R3), R2=5, R3=7 -> next cycle agex_v=1, agex_sr1=5, agex_sr2=7, agex_dr=1, R1 counter=1.
REQ-034 ADD R1 issued, next de_ir=0x1441 (ADD R2,R1,R1) -> dep_stall=1, ld_de=0, agex_v=0 until R1 writeback.
REQ-035 With DECODE_BYPASS_EN: wb_v=1, wb_ld_reg=1, wb_dr=1, wb_data=0x00AA in stall cycle -> dep_stall=0, agex_sr1=agex_sr2=0x00AA; without macro: one extra stall cycle.
REQ-036 de_ir=0x0402 (BRz) with CC counter 0 -> v_de_br_stall=1, dep_stall=0; with CC counter 1 -> both 1.
REQ-037 mem_stall=1 for 3 cycles with valid ADD in decode -> AGEX fields held, counters unchanged, ld_de=0; release -> issue next cycle.
REQ-038 reset asserted while counters nonzero and agex_v=1 -> next cycle all counters 0, agex_v=0, dep_stall=0.
